// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master drives requests; the slave (the converter) returns status and results.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic                  sign_en;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  negative;
  logic                  overflow;

  modport master (
    output start, sign_en, bin_in,
    input  busy, done, bcd_out, negative, overflow
  );

  modport slave (
    input  start, sign_en, bin_in,
    output busy, done, bcd_out, negative, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with signed input support, overflow detection and a start/busy/done handshake.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic         Clk,
  input  logic         Reset,
  bin2bcd_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  bin_sr;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     acc_adj;
  logic [CW-1:0]     cnt;
  logic              sign_q;
  logic              nonzero_q;
  logic              ovf_track;
  logic              is_neg;
  logic [WIDTH-1:0]  magnitude;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is still the
  // correct unsigned magnitude.
  always_comb begin
    is_neg    = bus.sign_en & bus.bin_in[WIDTH-1];
    magnitude = is_neg ? -bus.bin_in : bus.bin_in;
  end

  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      bin_sr       <= '0;
      acc          <= '0;
      cnt          <= '0;
      sign_q       <= 1'b0;
      nonzero_q    <= 1'b0;
      ovf_track    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bcd_out  <= '0;
      bus.negative <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr    <= magnitude;
            sign_q    <= is_neg;
            nonzero_q <= |bus.bin_in;
            acc       <= '0;
            ovf_track <= 1'b0;
            cnt       <= CW'(WIDTH);
            bus.busy  <= 1'b1;
            state     <= CONVERT;
          end
        end
        // Any bit pushed out of the top digit means the value needs more digits.
        CONVERT: begin
          acc       <= {acc_adj[BW-2:0], bin_sr[WIDTH-1]};
          ovf_track <= ovf_track | acc_adj[BW-1];
          bin_sr    <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt       <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          bus.bcd_out  <= acc;
          bus.negative <= sign_q & nonzero_q;
          bus.overflow <= ovf_track;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
